// File: rtl/mem_writeback_if.sv
// Execute-side operation handshake, data-memory port and register-file write port of the writeback stage.
// The master side is the surrounding core/memory; the slave side is the mem_writeback stage.
interface mem_writeback_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  ex_valid;
  logic                  ex_ready;
  logic [DATA_WIDTH-1:0] ALUResult;
  logic [DATA_WIDTH-1:0] WriteData;
  logic [DATA_WIDTH-1:0] PCPlus4;
  logic [4:0]            rd;
  logic [1:0]            ResultSrc;
  logic                  MemWrite;
  logic                  RegWrite;
  logic [2:0]            funct3;
  logic                  mem_req;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [3:0]            mem_wstrb;
  logic                  mem_ack;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic [4:0]            AD3;
  logic [DATA_WIDTH-1:0] Result;
  logic                  WE3;
  logic                  misalign;

  modport master (
    output ex_valid, ALUResult, WriteData, PCPlus4, rd, ResultSrc, MemWrite, RegWrite, funct3,
    output mem_ack, mem_rdata,
    input  ex_ready, mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, AD3, Result, WE3, misalign
  );

  modport slave (
    input  ex_valid, ALUResult, WriteData, PCPlus4, rd, ResultSrc, MemWrite, RegWrite, funct3,
    input  mem_ack, mem_rdata,
    output ex_ready, mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, AD3, Result, WE3, misalign
  );
endinterface

// File: rtl/mem_writeback.sv
// Memory-access/writeback stage: non-memory ops write back 1 cycle after accept, loads 1 cycle after ack.
// Backpressure: ex_ready is high only in IDLE, so at most one op is in flight; mem_req holds until mem_ack.
module mem_writeback #(
  parameter int DATA_WIDTH = 32
) (
  input logic            clk,
  input logic            rst_n,
  mem_writeback_if.slave bus
);

  typedef enum logic [1:0] {IDLE, MEM, WB} state_t;

  typedef struct packed {
    logic [4:0] rd;
    logic       regwrite;
    logic       memwrite;
    logic [2:0] funct3;
    logic [1:0] off;
  } op_t;

  state_t                state, state_n;
  op_t                   op, op_n;
  logic                  mem_req_q, mem_req_n;
  logic                  mem_we_q, mem_we_n;
  logic [DATA_WIDTH-1:0] mem_addr_q, mem_addr_n;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_n;
  logic [3:0]            mem_wstrb_q, mem_wstrb_n;
  logic [4:0]            ad3_q, ad3_n;
  logic [DATA_WIDTH-1:0] result_q, result_n;
  logic                  we3_q, we3_n;
  logic                  misalign_q, misalign_n;

  logic                  is_mem;
  logic                  access_ok;
  logic [DATA_WIDTH-1:0] st_data;
  logic [3:0]            st_strb;

  function automatic logic [DATA_WIDTH-1:0] load_ext(input logic [DATA_WIDTH-1:0] w,
                                                     input logic [2:0] f3,
                                                     input logic [1:0] off);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = off[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  load_ext = {{24{b[7]}}, b};
      3'b001:  load_ext = {{16{h[15]}}, h};
      3'b100:  load_ext = {24'b0, b};
      3'b101:  load_ext = {16'b0, h};
      default: load_ext = w;
    endcase
  endfunction

  // Decode of the operation currently offered by the execute stage.
  always_comb begin
    is_mem = bus.MemWrite || (bus.ResultSrc == 2'd1);
    case (bus.funct3)
      3'b000:  access_ok = 1'b1;
      3'b001:  access_ok = ~bus.ALUResult[0];
      3'b010:  access_ok = (bus.ALUResult[1:0] == 2'b00);
      3'b100:  access_ok = ~bus.MemWrite;
      3'b101:  access_ok = ~bus.MemWrite & ~bus.ALUResult[0];
      default: access_ok = 1'b0;
    endcase
    case (bus.funct3[1:0])
      2'b00: begin
        st_data = {4{bus.WriteData[7:0]}};
        st_strb = 4'b0001 << bus.ALUResult[1:0];
      end
      2'b01: begin
        st_data = {2{bus.WriteData[15:0]}};
        st_strb = 4'b0011 << bus.ALUResult[1:0];
      end
      default: begin
        st_data = bus.WriteData;
        st_strb = 4'b1111;
      end
    endcase
  end

  always_comb begin
    state_n     = state;
    op_n        = op;
    mem_req_n   = mem_req_q;
    mem_we_n    = mem_we_q;
    mem_addr_n  = mem_addr_q;
    mem_wdata_n = mem_wdata_q;
    mem_wstrb_n = mem_wstrb_q;
    ad3_n       = ad3_q;
    result_n    = result_q;
    we3_n       = 1'b0;
    misalign_n  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.ex_valid) begin
          op_n.rd       = bus.rd;
          op_n.regwrite = bus.RegWrite;
          op_n.memwrite = bus.MemWrite;
          op_n.funct3   = bus.funct3;
          op_n.off      = bus.ALUResult[1:0];
          if (!is_mem) begin
            state_n  = WB;
            we3_n    = bus.RegWrite && (bus.rd != 5'd0);
            ad3_n    = bus.rd;
            result_n = (bus.ResultSrc == 2'd2) ? bus.PCPlus4 : bus.ALUResult;
          end else if (!access_ok) begin
            misalign_n = 1'b1;
          end else begin
            state_n     = MEM;
            mem_req_n   = 1'b1;
            mem_we_n    = bus.MemWrite;
            mem_addr_n  = {bus.ALUResult[DATA_WIDTH-1:2], 2'b00};
            mem_wdata_n = bus.MemWrite ? st_data : mem_wdata_q;
            mem_wstrb_n = bus.MemWrite ? st_strb : 4'b0000;
          end
        end
      end
      MEM: begin
        if (bus.mem_ack) begin
          mem_req_n   = 1'b0;
          mem_we_n    = 1'b0;
          mem_wstrb_n = 4'b0000;
          if (op.memwrite) begin
            state_n = IDLE;
          end else begin
            state_n  = WB;
            we3_n    = op.regwrite && (op.rd != 5'd0);
            ad3_n    = op.rd;
            result_n = load_ext(bus.mem_rdata, op.funct3, op.off);
          end
        end
      end
      WB:      state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      op          <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= 4'b0000;
      ad3_q       <= 5'd0;
      result_q    <= '0;
      we3_q       <= 1'b0;
      misalign_q  <= 1'b0;
    end else begin
      state       <= state_n;
      op          <= op_n;
      mem_req_q   <= mem_req_n;
      mem_we_q    <= mem_we_n;
      mem_addr_q  <= mem_addr_n;
      mem_wdata_q <= mem_wdata_n;
      mem_wstrb_q <= mem_wstrb_n;
      ad3_q       <= ad3_n;
      result_q    <= result_n;
      we3_q       <= we3_n;
      misalign_q  <= misalign_n;
    end
  end

  assign bus.ex_ready  = (state == IDLE);
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_wstrb = mem_wstrb_q;
  assign bus.AD3       = ad3_q;
  assign bus.Result    = result_q;
  assign bus.WE3       = we3_q;
  assign bus.misalign  = misalign_q;

endmodule

// File: tb/tb_mem_writeback.sv
// Bench for mem_writeback: directed and random ops, expected events queued at issue time and
// matched by an independent monitor; a responder process plays the data memory.
module tb_mem_writeback;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mem_writeback_if #(.DATA_WIDTH(32)) bus ();
  mem_writeback #(.DATA_WIDTH(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {logic [4:0] rd; logic [31:0] res; bit is_load; int cyc;} wb_t;
  typedef struct {logic [31:0] addr; bit we; logic [31:0] wdata; logic [3:0] strb; int waitc; int cyc;} mem_t;
  typedef struct {int waitc; logic [31:0] rdata;} rsp_t;

  wb_t  exp_wb[$];
  mem_t exp_mem[$];
  rsp_t rsp_q[$];
  int   exp_mis[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   ack_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model plus driver for one operation.
  task automatic issue(input logic [31:0] alu, input logic [31:0] wd, input logic [31:0] pc4,
                       input logic [4:0] rd, input logic [1:0] rsrc, input bit mw, input bit rw,
                       input logic [2:0] f3, input int waitc, input logic [31:0] rdata);
    bit          is_mem, sgn, ok;
    int          off, size, t;
    logic [31:0] v, wdat;
    logic [3:0]  strb;
    is_mem = mw || (rsrc == 2'd1);
    off    = int'(alu % 4);
    size   = 0;
    sgn    = 0;
    if (mw) begin
      if (f3 == 3'd0) size = 1; else if (f3 == 3'd1) size = 2; else if (f3 == 3'd2) size = 4;
    end else begin
      case (f3)
        3'd0: begin size = 1; sgn = 1; end
        3'd1: begin size = 2; sgn = 1; end
        3'd2: size = 4;
        3'd4: size = 1;
        3'd5: size = 2;
        default: size = 0;
      endcase
    end
    ok = (size != 0) && ((off % (size == 0 ? 1 : size)) == 0);

    @(negedge clk);
    bus.ALUResult = alu; bus.WriteData = wd; bus.PCPlus4 = pc4; bus.rd = rd;
    bus.ResultSrc = rsrc; bus.MemWrite = mw; bus.RegWrite = rw; bus.funct3 = f3;
    bus.ex_valid = 1'b1;
    t = 0;
    while (!bus.ex_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!bus.ex_ready) begin
      chk("accept_timeout", 32'd0, 32'd1);
      bus.ex_valid = 1'b0;
      return;
    end

    if (!is_mem) begin
      if (rw && rd != 0) exp_wb.push_back('{rd, (rsrc == 2'd2) ? pc4 : alu, 1'b0, cyc + 1});
    end else if (!ok) begin
      exp_mis.push_back(cyc + 1);
    end else if (mw) begin
      if (size == 1) wdat = (wd & 32'hFF) * 32'h0101_0101;
      else if (size == 2) wdat = (wd & 32'hFFFF) * 32'h0001_0001;
      else wdat = wd;
      strb = 4'(((1 << size) - 1) << off);
      exp_mem.push_back('{alu - off, 1'b1, wdat, strb, waitc, cyc + 1});
      rsp_q.push_back('{waitc, rdata});
    end else begin
      v = rdata >> (8 * off);
      if (size < 4) begin
        v = v & ((32'd1 << (8 * size)) - 1);
        if (sgn && v >= (32'd1 << (8 * size - 1))) v = v - (32'd1 << (8 * size));
      end
      exp_mem.push_back('{alu - off, 1'b0, 32'd0, 4'd0, waitc, cyc + 1});
      rsp_q.push_back('{waitc, rdata});
      if (rw && rd != 0 && waitc >= 0) exp_wb.push_back('{rd, v, 1'b1, 0});
    end

    @(posedge clk);
    #1;
    bus.ex_valid  = 1'b0;
    bus.ALUResult = $urandom; bus.WriteData = $urandom; bus.PCPlus4 = $urandom;
    bus.rd = 5'($urandom); bus.ResultSrc = 2'($urandom); bus.MemWrite = 1'($urandom);
    bus.RegWrite = 1'($urandom); bus.funct3 = 3'($urandom);
  endtask

  // Data-memory responder; acks strays outside requests to show they are ignored.
  initial begin
    rsp_t r;
    bus.mem_ack = 1'b0;
    bus.mem_rdata = 32'd0;
    forever begin
      @(negedge clk);
      if (bus.mem_req) begin
        r = (rsp_q.size() != 0) ? rsp_q.pop_front() : '{0, 32'd0};
        bus.mem_ack = 1'b0;
        if (r.waitc < 0) begin
          while (bus.mem_req) @(negedge clk);
        end else begin
          repeat (r.waitc) @(negedge clk);
          bus.mem_ack = 1'b1;
          bus.mem_rdata = r.rdata;
          ack_cyc = cyc + 1;
          @(negedge clk);
          bus.mem_ack = 1'b0;
          bus.mem_rdata = $urandom;
        end
      end else begin
        bus.mem_ack = ($urandom_range(0, 3) == 0);
        bus.mem_rdata = $urandom;
      end
    end
  end

  // Monitor: pops expectations whenever the stage presents an output event.
  initial begin
    wb_t         w;
    mem_t        m;
    bit          prev_req = 1'b0;
    bit          stable = 1'b1;
    int          req_cnt = 0;
    logic [31:0] s_addr, s_wdata;
    logic [3:0]  s_strb;
    bit          s_we;
    m = '{32'd0, 1'b0, 32'd0, 4'd0, 0, 0};
    forever begin
      @(negedge clk);
      if (bus.WE3) begin
        if (exp_wb.size() == 0) chk("wb_unexpected", 32'd1, 32'd0);
        else begin
          w = exp_wb.pop_front();
          chk("wb_rd", 32'(bus.AD3), 32'(w.rd));
          chk("wb_result", bus.Result, w.res);
          chk("wb_cycle", cyc, w.is_load ? ack_cyc : w.cyc);
        end
      end
      if (bus.misalign) begin
        if (exp_mis.size() == 0) chk("misalign_unexpected", 32'd1, 32'd0);
        else begin
          chk("misalign_cycle", cyc, exp_mis.pop_front());
          chk("misalign_no_req", 32'(bus.mem_req), 32'd0);
          chk("misalign_ready", 32'(bus.ex_ready), 32'd1);
        end
      end
      if (bus.mem_req && !prev_req) begin
        if (exp_mem.size() == 0) chk("req_unexpected", 32'd1, 32'd0);
        else begin
          m = exp_mem.pop_front();
          chk("req_cycle", cyc, m.cyc);
          chk("req_addr", bus.mem_addr, m.addr);
          chk("req_we", 32'(bus.mem_we), 32'(m.we));
          if (m.we) begin
            chk("req_wdata", bus.mem_wdata, m.wdata);
            chk("req_wstrb", 32'(bus.mem_wstrb), 32'(m.strb));
          end
        end
        req_cnt = 1; stable = 1'b1;
        s_addr = bus.mem_addr; s_wdata = bus.mem_wdata; s_strb = bus.mem_wstrb; s_we = bus.mem_we;
      end else if (bus.mem_req && prev_req) begin
        req_cnt++;
        if (bus.mem_addr !== s_addr || bus.mem_wdata !== s_wdata ||
            bus.mem_wstrb !== s_strb || bus.mem_we !== s_we) stable = 1'b0;
      end else if (!bus.mem_req && prev_req) begin
        chk("req_stable", 32'(stable), 32'd1);
        if (m.waitc >= 0) chk("req_cycles", req_cnt, m.waitc + 1);
      end
      prev_req = bus.mem_req;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [2:0] ld_f3[5];
    logic [2:0] f3;
    int         kind, t;
    ld_f3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    bus.ex_valid = 1'b0; bus.ALUResult = '0; bus.WriteData = '0; bus.PCPlus4 = '0;
    bus.rd = '0; bus.ResultSrc = '0; bus.MemWrite = 1'b0; bus.RegWrite = 1'b0; bus.funct3 = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
    chk("rst_we3", 32'(bus.WE3), 32'd0);
    chk("rst_misalign", 32'(bus.misalign), 32'd0);
    chk("rst_wstrb", 32'(bus.mem_wstrb), 32'd0);
    chk("rst_result", bus.Result, 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'd0);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ex_ready", 32'(bus.ex_ready), 32'd1);

    issue(32'h0000_1234, 32'h0, 32'h0, 5'd5, 2'd0, 1'b0, 1'b1, 3'b000, 0, 32'h0);
    issue(32'h0000_0103, 32'h0, 32'h0, 5'd6, 2'd1, 1'b0, 1'b1, 3'b000, 3, 32'h8011_2233);
    issue(32'h0000_0103, 32'h0, 32'h0, 5'd6, 2'd1, 1'b0, 1'b1, 3'b100, 0, 32'h8011_2233);
    issue(32'h0000_0202, 32'hDEAD_BEEF, 32'h0, 5'd3, 2'd0, 1'b1, 1'b0, 3'b001, 1, 32'h0);
    issue(32'h0000_0201, 32'h0, 32'h0, 5'd9, 2'd1, 1'b0, 1'b1, 3'b010, 0, 32'h0);
    issue(32'h0000_0040, 32'h0, 32'h0000_0100, 5'd0, 2'd2, 1'b0, 1'b1, 3'b000, 0, 32'h0);
    issue(32'h0000_0040, 32'h0, 32'h2000_0004, 5'd1, 2'd2, 1'b0, 1'b1, 3'b000, 0, 32'h0);

    for (int i = 0; i < 300; i++) begin
      kind = $urandom_range(0, 5);
      if (kind >= 4) f3 = 3'($urandom_range(0, 2));
      else f3 = ld_f3[$urandom_range(0, 4)];
      if ($urandom_range(0, 7) == 0) f3 = 3'($urandom_range(0, 7));
      case (kind)
        0: issue($urandom, $urandom, $urandom, 5'($urandom), $urandom_range(0, 1) ? 2'd0 : 2'd3,
                 1'b0, $urandom_range(0, 3) != 0, 3'($urandom), 0, 32'h0);
        1: issue($urandom, $urandom, $urandom, 5'($urandom), 2'd2, 1'b0,
                 $urandom_range(0, 3) != 0, 3'($urandom), 0, 32'h0);
        2, 3: issue($urandom & 32'hFFFF, $urandom, $urandom, 5'($urandom), 2'd1, 1'b0,
                    $urandom_range(0, 3) != 0, f3, $urandom_range(0, 3), $urandom);
        default: issue($urandom & 32'hFFFF, $urandom, $urandom, 5'($urandom), 2'($urandom), 1'b1,
                       $urandom_range(0, 1) == 1, f3, $urandom_range(0, 3), 32'h0);
      endcase
      repeat ($urandom_range(0, 1)) @(negedge clk);
    end

    // Abandon a load mid-request with an asynchronous reset.
    issue(32'h0000_0300, 32'h0, 32'h0, 5'd7, 2'd1, 1'b0, 1'b1, 3'b010, -1, 32'h0);
    repeat (3) @(negedge clk);
    chk("pre_reset_req", 32'(bus.mem_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_mem_req", 32'(bus.mem_req), 32'd0);
    chk("mid_rst_mem_we", 32'(bus.mem_we), 32'd0);
    chk("mid_rst_mem_addr", bus.mem_addr, 32'd0);
    chk("mid_rst_ad3", 32'(bus.AD3), 32'd0);
    chk("mid_rst_we3", 32'(bus.WE3), 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 32'(bus.ex_ready), 32'd1);
    issue(32'h0000_0055, 32'h0, 32'h0, 5'd12, 2'd0, 1'b0, 1'b1, 3'b000, 0, 32'h0);
    issue(32'h0000_0306, 32'h0, 32'h0, 5'd13, 2'd1, 1'b0, 1'b1, 3'b101, 2, 32'hA5C3_1234);

    t = 0;
    while ((exp_wb.size() != 0 || exp_mem.size() != 0 || exp_mis.size() != 0) && t < 50) begin
      @(negedge clk);
      t++;
    end
    repeat (4) @(negedge clk);
    chk("drain_wb", exp_wb.size(), 32'd0);
    chk("drain_mem", exp_mem.size(), 32'd0);
    chk("drain_misalign", exp_mis.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_writeback.md
# mem_writeback

Memory-access and writeback stage for the multi-cycle RISC-V core. Accepts one completed execute result per handshake (ALU result, store data, destination register, control), performs the load or store against a ready/ack data-memory port, and drives the register file write port (`AD3`, `WD3`, `WE3`) that the execute stage reads from. It is the producer of `Result`/`WE3`, closing the loop opened by the execute stage.

## Interface
- `DATA_WIDTH`, 32, datapath width; only 32 supported.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `ex_valid`  in  1  execute stage presents an operation.
- `ex_ready`  out  1  stage can accept; high only in IDLE.
- `ALUResult`  in  32  ALU output; memory address for loads/stores.
- `WriteData`  in  32  store data (rs2 value).
- `PCPlus4`  in  32  link value for JAL/JALR.
- `rd`  in  5  destination register.
- `ResultSrc`  in  2  0 ALU, 1 memory, 2 PCPlus4, 3 reserved (treated as 0).
- `MemWrite`  in  1  store operation.
- `RegWrite`  in  1  operation writes rd.
- `funct3`  in  3  access size/sign.
- `mem_req`  out  1  memory request; held until `mem_ack`.
- `mem_we`  out  1  1 store, 0 load.
- `mem_addr`  out  32  word-aligned address (`ALUResult & ~3`).
- `mem_wdata`  out  32  lane-shifted store data.
- `mem_wstrb`  out  4  byte enables, bit i = byte lane i.
- `mem_ack`  in  1  request complete; `mem_rdata` valid this cycle for loads.
- `mem_rdata`  in  32  read word.
- `AD3`  out  5  register file write address.
- `Result`  out  32  register file write data.
- `WE3`  out  1  register file write enable, one-cycle pulse.
- `misalign`  out  1  one-cycle pulse: access dropped (misaligned or illegal funct3).

## Operation
- States: IDLE, MEM, WB. Accept when `ex_valid && ex_ready`; all inputs captured into registers on that edge.
- Memory op = `MemWrite` or `ResultSrc==1`. Non-memory op: IDLE -> WB.
- Memory op, legal and aligned: IDLE -> MEM. In MEM `mem_req=1`; on `mem_ack`: load -> WB, store -> IDLE.
- Alignment: byte any address; half needs addr[0]=0; word needs addr[1:0]=0. Legal funct3: loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000/001/010. Violation: no request, `misalign` pulses the cycle after accept, no writeback, return IDLE.
- Store lanes: SB data[7:0] replicated, strobe `0001<<addr[1:0]`; SH data[15:0] replicated, strobe `0011<<addr[1:0]`; SW strobe 1111.
- Load: select byte/half by addr[1:0] from `mem_rdata`; LB/LH sign-extend, LBU/LHU zero-extend; captured on ack edge.
- WB: `WE3 = RegWrite && rd!=0`, `AD3=rd`, `Result` per `ResultSrc`. WB -> IDLE unconditionally.
- `mem_ack` outside MEM ignored. `mem_addr`, `mem_we`, `mem_wdata`, `mem_wstrb` stable throughout MEM.

## Timing
- Reset (async, immediate): state IDLE; `mem_req`, `mem_we`, `WE3`, `misalign`, `mem_wstrb` = 0; `mem_addr`, `mem_wdata`, `Result`, `AD3` = 0; `ex_ready` = 1 after reset deasserts.
- Reset mid-MEM: `mem_req` drops same instant; transaction abandoned, no writeback.
- Non-memory op accepted edge N: `WE3` high cycle N+1; `ex_ready` low N+1, high N+2. Throughput one op per 2 cycles.
- Memory op accepted edge N: `mem_req` high from N+1. Ack sampled at edge M: load `WE3` high cycle M+1; store `ex_ready` high cycle M+1. Ack in first MEM cycle allowed (zero wait).
- All outputs registered; no combinational path from `mem_ack`/`ex_valid` to any output except `ex_ready` (state decode only).

## Test plan
- ADD result: accept `ALUResult=0x0000_1234`, rd=5, RegWrite, ResultSrc=0 -> next cycle `WE3=1`, `AD3=5`, `Result=0x1234`; `mem_req` never asserts.
- LB sign: addr 0x103, rdata 0x80_11_22_33, ack after 3 wait cycles -> `mem_req` high 4 cycles, `Result=0xFFFF_FF80`; same with LBU -> 0x0000_0080.
- SH: addr 0x202, WriteData 0xDEAD_BEEF -> `mem_addr=0x200`, `mem_wdata=0xBEEF_BEEF`, `mem_wstrb=1100`, `mem_we=1`; after ack no `WE3`.
- Misaligned LW at 0x201 -> `misalign` one-cycle pulse, no `mem_req`, no `WE3`, `ex_ready` back high.
- Write to x0: JAL rd=0, ResultSrc=2 -> `WE3` stays 0; rd=1 -> `Result=PCPlus4`.
- Async reset during MEM with `mem_ack` never given -> `mem_req` 0 immediately, all outputs at reset values, next op accepted normally.
